// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, load-use/branch stalls, data-memory wait FSM
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   RsD, RtD, RsE, RtE              source register numbers in D and E
//   WriteRegE/M/W, RegWriteE/M/W    destination register and write enable per stage
//   MemtoRegE, MemtoRegM, BranchD   load-in-E, load-in-M, branch-in-D
//   MemAccessM, MemReadyM           data memory request in M and its completion
//   StallF/D/E/M, FlushE, FlushW    stage holds and bubble inserts (combinational)
//   ForwardAE/BE, ForwardAD/BD      operand selects for E ALU and D comparator (combinational)
//   MemTimeout                      sticky data-memory timeout flag (registered)
//   StallCount                      saturating count of fetch-stall cycles (registered)
module hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             MemAccessM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    state_t           r_state;
    logic [7:0]       r_wcnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_memstall;
    logic w_lwstall;
    logic w_branchstall;
    logic w_hzstall;

    // Register 0 is hard-wired, so it never forwards; M is newer than W and wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (src != 5'd0 && src == WriteRegM && RegWriteM)
            return 2'b10;
        else if (src != 5'd0 && src == WriteRegW && RegWriteW)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_memstall = 1'b0;
        case (r_state)
            S_IDLE:  w_memstall = MemAccessM & ~MemReadyM;
            S_WAIT:  w_memstall = ~MemReadyM;
            S_ERR:   w_memstall = 1'b1;
            default: w_memstall = 1'b0;
        endcase
    end

    assign w_lwstall     = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
    assign w_branchstall = BranchD &
                           ((RegWriteE & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                            (MemtoRegM & ((WriteRegM == RsD) | (WriteRegM == RtD))));
    // A memory stall freezes the whole pipe, so a pending load-use/branch hazard
    // simply stays on the inputs and is re-evaluated once memory completes.
    assign w_hzstall     = ~w_memstall & (w_lwstall | w_branchstall);

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        if (!reset) begin
            StallF    = w_memstall | w_hzstall;
            StallD    = w_memstall | w_hzstall;
            StallE    = w_memstall;
            StallM    = w_memstall;
            FlushE    = w_hzstall;
            FlushW    = w_memstall;
            ForwardAE = fwd_sel(RsE);
            ForwardBE = fwd_sel(RtE);
            ForwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
            ForwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 8'd0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (StallF && r_stall_cnt != {CNT_W{1'b1}})
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (MemAccessM && !MemReadyM) begin
                        r_state <= S_WAIT;
                        r_wcnt  <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (MemReadyM) begin
                        r_state <= S_IDLE;
                        r_wcnt  <= 8'd0;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                        if (r_wcnt + 8'd1 == MAX_WAIT_L) begin
                            r_state   <= S_ERR;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wcnt  <= 8'd0;
                end
            endcase
        end
    end

    assign MemTimeout = r_timeout;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with a cycle model and directed vectors
module tb_hazard_ctrl;
    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
    logic       MemAccessM, MemReadyM;

    logic        StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD, MemTimeout;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCount;
    logic        StallF4, StallD4, StallE4, StallM4, FlushE4, FlushW4, ForwardAD4, ForwardBD4, MemTimeout4;
    logic [1:0]  ForwardAE4, ForwardBE4;
    logic [3:0]  StallCount4;

    int     n_pass = 0;
    int     n_total = 0;
    bit     started = 0;
    int     m_run = 0;
    bit     m_err = 0;
    longint m_cnt = 0;
    int     m_cnt4 = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .MemTimeout(MemTimeout), .StallCount(StallCount)
    );

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .StallF(StallF4), .StallD(StallD4), .StallE(StallE4), .StallM(StallM4),
        .FlushE(FlushE4), .FlushW(FlushW4), .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
        .ForwardAD(ForwardAD4), .ForwardBD(ForwardBD4), .MemTimeout(MemTimeout4), .StallCount(StallCount4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] r);
        if (r != 0 && r == WriteRegM && RegWriteM) return 2'd2;
        if (r != 0 && r == WriteRegW && RegWriteW) return 2'd1;
        return 2'd0;
    endfunction

    // memory stall: stuck after timeout, or memory not ready while a request is new or already pending
    function automatic bit exp_mem();
        return m_err || (!MemReadyM && (m_run > 0 || MemAccessM));
    endfunction

    function automatic bit exp_hz();
        bit lw, br;
        lw = MemtoRegE && (RtE == RsD || RtE == RtD);
        br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                         (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
        return lw || br;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_err = 0; m_cnt = 0; m_cnt4 = 0; started = 1;
        end else begin
            bit ms;
            ms = exp_mem();
            if (ms || exp_hz()) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (ms) begin
                m_run++;
                if (m_run == MAX_WAIT) m_err = 1;
            end else begin
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit ms, hz;
            logic [11:0] ev;
            ms = !reset && exp_mem();
            hz = !reset && !ms && exp_hz();
            ev = {ms || hz, ms || hz, ms, ms, hz, ms,
                  reset ? 2'd0 : exp_fwd(RsE), reset ? 2'd0 : exp_fwd(RtE),
                  !reset && RsD != 0 && RsD == WriteRegM && RegWriteM,
                  !reset && RtD != 0 && RtD == WriteRegM && RegWriteM};
            check("StallF", StallF, ev[11]);
            check("StallD", StallD, ev[10]);
            check("StallE", StallE, ev[9]);
            check("StallM", StallM, ev[8]);
            check("FlushE", FlushE, ev[7]);
            check("FlushW", FlushW, ev[6]);
            check("ForwardAE", ForwardAE, ev[5:4]);
            check("ForwardBE", ForwardBE, ev[3:2]);
            check("ForwardAD", ForwardAD, ev[1]);
            check("ForwardBD", ForwardBD, ev[0]);
            check("MemTimeout", MemTimeout, m_err);
            check("StallCount", StallCount, m_cnt);
            check("dut4_outs", {StallF4, StallD4, StallE4, StallM4, FlushE4, FlushW4,
                                ForwardAE4, ForwardBE4, ForwardAD4, ForwardBD4}, ev);
            check("dut4_MemTimeout", MemTimeout4, m_err);
            check("dut4_StallCount", StallCount4, m_cnt4);
        end
    end

    task automatic clr();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
        MemAccessM = 0; MemReadyM = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        clr();
        // reset with every hazard source active: outputs must be quiet
        RsE = 5; WriteRegM = 5; RegWriteM = 1; MemtoRegE = 1; RtE = 3; RsD = 3; MemAccessM = 1;
        tick(2);
        #1;
        check("lit_reset_StallF", StallF, 0);
        check("lit_reset_ForwardAE", ForwardAE, 0);
        reset = 0; clr();
        tick(1);
        #1;
        check("lit_reset_StallCount", StallCount, 0);
        check("lit_reset_MemTimeout", MemTimeout, 0);

        // forwarding priority
        RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1; #1;
        check("lit_fwdAE_M", ForwardAE, 2);
        RegWriteM = 0; #1;
        check("lit_fwdAE_W", ForwardAE, 1);
        RsE = 0; #1;
        check("lit_fwdAE_zero", ForwardAE, 0);
        RtE = 5; RsD = 5; RegWriteM = 1; RtD = 6; #1;
        check("lit_fwdBE_M", ForwardBE, 2);
        check("lit_fwdAD", ForwardAD, 1);
        tick(1); clr();

        // load-use for two cycles
        MemtoRegE = 1; RtE = 7; RsD = 7; #1;
        check("lit_lw_StallF", StallF, 1);
        check("lit_lw_FlushE", FlushE, 1);
        check("lit_lw_StallE", StallE, 0);
        tick(2); clr(); #1;
        check("lit_lw_count", StallCount, 2);

        // three memory wait cycles then ready
        MemAccessM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lit_mw_StallM", StallM, 1);
            check("lit_mw_FlushW", FlushW, 1);
            tick(1);
        end
        MemReadyM = 1; #1;
        check("lit_mw_release", StallF, 0);
        tick(1); clr(); #1;
        check("lit_mw_count", StallCount, 5);
        check("lit_mw_idle", StallF, 0);

        // branch hazard under a memory stall
        BranchD = 1; RegWriteE = 1; WriteRegE = 9; RsD = 9; MemAccessM = 1; MemReadyM = 0; #1;
        check("lit_br_mem_FlushE", FlushE, 0);
        check("lit_br_mem_StallE", StallE, 1);
        tick(1);
        MemReadyM = 1; #1;
        check("lit_br_rdy_FlushE", FlushE, 1);
        check("lit_br_rdy_StallE", StallE, 0);
        tick(1); MemAccessM = 0; MemReadyM = 0; #1;
        check("lit_br_after_FlushE", FlushE, 1);
        tick(1); clr(); #1;
        check("lit_br_count", StallCount, 8);

        // load-use held across a memory stall: counted once per cycle, flushed after release
        MemtoRegE = 1; RtE = 4; RtD = 4; RsD = 1; MemAccessM = 1;
        tick(2);
        MemReadyM = 1; #1;
        check("lit_lwmem_FlushE", FlushE, 1);
        tick(1); clr(); #1;
        check("lit_lwmem_count", StallCount, 11);
        check("lit_lwmem_noflush", FlushE, 0);

        // timeout and saturation, starting from a fresh reset
        reset = 1; tick(1); reset = 0; #1;
        check("lit_to_cleared", StallCount, 0);
        MemAccessM = 1;
        tick(MAX_WAIT - 1);
        check("lit_to_before", MemTimeout, 0);
        tick(1);
        check("lit_to_set", MemTimeout, 1);
        check("lit_to_count", StallCount, 15);
        MemReadyM = 1; MemAccessM = 0; #1;
        check("lit_to_held", StallM, 1);
        tick(5);
        check("lit_sat_count4", StallCount4, 15);
        check("lit_sat_count32", StallCount, 20);
        tick(2);
        check("lit_sat_stays", StallCount4, 15);

        // reset aborts ERR
        reset = 1; MemReadyM = 0; #1;
        check("lit_rst_err_StallF", StallF, 0);
        tick(1); reset = 0; MemAccessM = 1; MemReadyM = 1; #1;
        check("lit_rst_err_timeout", MemTimeout, 0);
        check("lit_rst_err_idle", StallF, 0);
        tick(2); clr();
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, the maximum consecutive data-memory wait cycles before timeout (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 32, the width of the stall-cycle counter.
REQ-003 SHALL use a single clock: clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have inputs RsD, RtD, RsE, RtE, each 5 bits: source register numbers in the D and E stages.
REQ-006 SHALL have inputs WriteRegE, WriteRegM, WriteRegW, each 5 bits: destination register numbers per stage.
REQ-007 SHALL have 1-bit inputs RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD: control bits per stage.
REQ-008 SHALL have 1-bit inputs MemAccessM (load or store in M) and MemReadyM (data memory completes this cycle).
REQ-009 SHALL have 1-bit outputs StallF, StallD, StallE, StallM (hold stage registers), FlushE (bubble into E) and FlushW (bubble into W).
REQ-010 SHALL have 2-bit outputs ForwardAE and ForwardBE (E-stage ALU operand selects) and 1-bit outputs ForwardAD and ForwardBD (D-stage comparator selects).
REQ-011 SHALL have 1-bit output MemTimeout (sticky error) and CNT_W-bit output StallCount (performance counter).

Function
REQ-012 ForwardAE SHALL be 10 if RsE!=0, RsE==WriteRegM and RegWriteM; otherwise 01 if RsE!=0, RsE==WriteRegW and RegWriteW; otherwise 00. M has priority over W.
REQ-013 ForwardBE SHALL follow REQ-012 with RtE in place of RsE.
REQ-014 ForwardAD SHALL be 1 if RsD!=0, RsD==WriteRegM and RegWriteM; ForwardBD SHALL be the same using RtD.
REQ-015 lwstall SHALL be MemtoRegE AND (RtE==RsD OR RtE==RtD).
REQ-016 branchstall SHALL be BranchD AND ((RegWriteE AND WriteRegE in {RsD,RtD}) OR (MemtoRegM AND WriteRegM in {RsD,RtD})).
REQ-017 The FSM SHALL have states IDLE, WAIT and ERR, plus an 8-bit wait counter wcnt.
REQ-018 IDLE with MemAccessM=1 and MemReadyM=0: memstall=1 this cycle; next state WAIT with wcnt=1.
REQ-019 WAIT with MemReadyM=0: memstall=1; wcnt increments; when the incremented wcnt equals MAX_WAIT, next state ERR.
REQ-020 WAIT with MemReadyM=1: memstall=0 in that cycle (M completes); next state IDLE with wcnt=0.
REQ-021 ERR: memstall=1 and MemTimeout=1; the FSM SHALL leave ERR only on reset.
REQ-022 If memstall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0. memstall overrides lw/branch stalls.
REQ-023 If memstall=0: StallF=StallD=FlushE=(lwstall OR branchstall), and StallE=StallM=FlushW=0.
REQ-024 Forward, stall and flush outputs SHALL be combinational within the cycle. State, wcnt, MemTimeout and StallCount SHALL be registered.
REQ-025 StallCount SHALL increment by 1 on each clock edge at which StallF=1, and SHALL saturate at all-ones without wrapping.
REQ-026 A load-use hazard arriving during memstall SHALL be evaluated again after memstall clears; it SHALL be neither lost nor double-counted.

Reset
REQ-027 On a clock edge with reset=1: state=IDLE, wcnt=0, MemTimeout=0, StallCount=0.
REQ-028 While reset=1, all stall and flush outputs SHALL be 0 and all forward selects SHALL be 0, regardless of the other inputs.
REQ-029 Reset in WAIT or ERR SHALL abort the wait; the cycle after reset is released, the block is in IDLE with memstall driven only by REQ-018.

Verification
REQ-030 Forwarding: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then RsE=0 -> ForwardAE=00.
REQ-031 Load-use: MemtoRegE=1, RtE=7, RsD=7 -> StallF=StallD=FlushE=1, StallE=0. StallCount increments by 1 per such cycle.
REQ-032 Memory wait: MemAccessM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF..StallM=1 and FlushW=1 for 3 cycles; released on the 4th cycle; state back to IDLE; StallCount=+3.
REQ-033 Timeout: MemAccessM=1, MemReadyM held 0 -> ERR reached after MAX_WAIT=15 stalled cycles; MemTimeout=1 and all stalls held even if MemReadyM rises; reset clears everything.
REQ-034 Branch plus memory stall at the same time: BranchD=1, RegWriteE=1, WriteRegE=RsD, memstall=1 -> FlushE=0 and StallE=1. The cycle after MemReadyM=1 -> FlushE=1 and StallE=0.
REQ-035 Saturation: with CNT_W=4 and 20 consecutive stall cycles -> StallCount=15 and stays 15.
